// File: rtl/fetch_unit_if.sv
// Bus between the fetch unit and its neighbours: RAM data in, controller strobes in,
// decoded instruction fields, flags, PC and RAM address out. No handshake; strobes act per cycle.
interface fetch_unit_if #(
    parameter int AW = 7,
    parameter int OW = 4,
    parameter int DW = 12,
    parameter int CW = 16
);
    logic [DW-1:0] DBUS;
    logic          PC_EN;
    logic          PC_LOAD;
    logic          IR_EN;
    logic          RDR_EN;
    logic          ALU_EN;
    logic          CF_IN;
    logic          OF_IN;
    logic          SF_IN;
    logic          ZF_IN;

    logic [OW-1:0] OPCODE;
    logic          I;
    logic [AW-1:0] ADDR;
    logic          CF;
    logic          OF;
    logic          SF;
    logic          ZF;
    logic [AW-1:0] PC;
    logic [AW-1:0] OPADDR;
    logic [AW-1:0] MEM_ADDR;
    logic [CW-1:0] ICOUNT;

    modport master (
        output DBUS, PC_EN, PC_LOAD, IR_EN, RDR_EN, ALU_EN, CF_IN, OF_IN, SF_IN, ZF_IN,
        input  OPCODE, I, ADDR, CF, OF, SF, ZF, PC, OPADDR, MEM_ADDR, ICOUNT
    );

    modport slave (
        input  DBUS, PC_EN, PC_LOAD, IR_EN, RDR_EN, ALU_EN, CF_IN, OF_IN, SF_IN, ZF_IN,
        output OPCODE, I, ADDR, CF, OF, SF, ZF, PC, OPADDR, MEM_ADDR, ICOUNT
    );
endinterface

// File: rtl/fetch_unit.sv
// PC/IR/EA/flag registers plus retired-instruction counter; all state updates one edge after the strobe.
// MEM_ADDR and OPADDR are combinational from registers (MEM_ADDR also from IR_EN); no backpressure.
module fetch_unit #(
    parameter int AW = 7,
    parameter int OW = 4,
    parameter int DW = 12,
    parameter int CW = 16
) (
    input logic         CLK,
    input logic         RST,
    fetch_unit_if.slave bus
);
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [AW-1:0] ea_q, ea_d;
    logic [3:0]    flags_q, flags_d;
    logic [CW-1:0] icount_q, icount_d;
    logic [AW-1:0] opaddr;

    // Indirect bit picks the pointer fetched into EA over the IR's direct address.
    assign opaddr = ir_q[AW] ? ea_q : ir_q[AW-1:0];

    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        ea_d     = ea_q;
        flags_d  = flags_q;
        icount_d = icount_q;

        if (bus.PC_LOAD) begin
            pc_d = opaddr;
        end else if (bus.PC_EN) begin
            pc_d = pc_q + AW'(1);
        end

        if (bus.IR_EN) begin
            ir_d     = bus.DBUS;
            icount_d = icount_q + CW'(1);
        end

        if (bus.RDR_EN) begin
            ea_d = bus.DBUS[AW-1:0];
        end

        if (bus.ALU_EN) begin
            flags_d = {bus.CF_IN, bus.OF_IN, bus.SF_IN, bus.ZF_IN};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q     <= '0;
            ir_q     <= '0;
            ea_q     <= '0;
            flags_q  <= '0;
            icount_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ea_q     <= ea_d;
            flags_q  <= flags_d;
            icount_q <= icount_d;
        end
    end

    assign bus.OPCODE   = ir_q[DW-1:DW-OW];
    assign bus.I        = ir_q[AW];
    assign bus.ADDR     = ir_q[AW-1:0];
    assign bus.CF       = flags_q[3];
    assign bus.OF       = flags_q[2];
    assign bus.SF       = flags_q[1];
    assign bus.ZF       = flags_q[0];
    assign bus.PC       = pc_q;
    assign bus.OPADDR   = opaddr;
    assign bus.MEM_ADDR = bus.IR_EN ? pc_q : opaddr;
    assign bus.ICOUNT   = icount_q;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Holds the processor's program counter (PC), instruction register (IR), indirect effective-address register (EA) and status-flag register.
- Sits directly upstream of the sequence controller. It supplies OPCODE, ADDR, I and the registered CF/OF/SF/ZF flags, and it consumes that controller's PC_EN, PC_LOAD, IR_EN, RDR_EN and ALU_EN strobes.
- Also drives the RAM address bus and keeps a retired-instruction count for debug.

Parameters:
- AW, 7, address / PC width (ADDR, PC, EA, MEM_ADDR)
- OW, 4, opcode width
- DW, 12, data/instruction bus width; must equal OW+1+AW
- CW, 16, retired-instruction counter width

Ports:
- CLK  input  1  system clock; all state changes on rising edge
- RST  input  1  synchronous, active-high reset
- DBUS  input  DW  RAM read data (instruction word or indirect pointer)
- PC_EN  input  1  increment PC
- PC_LOAD  input  1  load PC with operand address
- IR_EN  input  1  capture DBUS into IR; selects PC onto MEM_ADDR
- RDR_EN  input  1  capture DBUS[AW-1:0] into EA
- ALU_EN  input  1  capture ALU flags
- CF_IN, OF_IN, SF_IN, ZF_IN  input  1 each  raw ALU flags
- OPCODE  output  OW  IR[DW-1:DW-OW]
- I  output  1  IR[AW], indirect bit
- ADDR  output  AW  IR[AW-1:0]
- CF, OF, SF, ZF  output  1 each  registered flags
- PC  output  AW  current program counter
- OPADDR  output  AW  effective operand address
- MEM_ADDR  output  AW  RAM address
- ICOUNT  output  CW  retired-instruction count

Behaviour:
- Instruction word format: [DW-1:DW-OW] opcode, [AW] indirect bit I, [AW-1:0] address.
- Reset, sampled on a rising CLK edge with RST=1:
  - PC, IR, EA, flags and ICOUNT all clear to 0, so OPCODE=0, I=0, ADDR=0, CF=OF=SF=ZF=0.
  - RST overrides every enable asserted in the same cycle.
  - Reset asserted mid-instruction discards any partial state; there is no recovery of the PC.
- PC update, evaluated in priority order each edge:
  - RST: PC becomes 0.
  - Else PC_LOAD=1: PC becomes OPADDR, the value present before the edge. PC_LOAD beats PC_EN when both are asserted.
  - Else PC_EN=1: PC becomes PC+1 modulo 2^AW, so 127 wraps to 0 with no flag.
  - Else PC holds.
- IR: when IR_EN=1 the IR captures DBUS at the edge. The new OPCODE/I/ADDR are visible one cycle after the IR_EN edge. Otherwise the IR holds.
- EA: when RDR_EN=1, EA takes DBUS[AW-1:0]; otherwise EA holds.
  - When IR_EN and RDR_EN are asserted together, both capture the same DBUS.
- OPADDR is combinational: EA when I=1, otherwise ADDR.
- MEM_ADDR is combinational: PC when IR_EN=1 (fetch), otherwise OPADDR.
  - No latency beyond combinational delay, so RAM sees PC in the same cycle IR_EN is high.
- Flags: when ALU_EN=1, {CF,OF,SF,ZF} take {CF_IN,OF_IN,SF_IN,ZF_IN} at the edge. They hold otherwise, including across IR and PC updates.
- ICOUNT increments by 1 on each edge with IR_EN=1 and RST=0. It wraps from 2^CW-1 to 0.
- No combinational path from DBUS to any output except MEM_ADDR/OPADDR via the registers; OPADDR depends only on registered values.
- All registers are single-edge. There are no latches and no asynchronous logic.

Test Plan:
1. Reset: drive random enables with RST=1 for 2 cycles, then release → PC=0, OPCODE=0, I=0, ADDR=0, flags=0, ICOUNT=0. With PC_EN=1 afterward, PC=1 after the first edge.
2. Fetch: PC=5, IR_EN=1, DBUS=12'hA23 → MEM_ADDR=5 during the IR_EN cycle. Next cycle OPCODE=4'hA, I=0, ADDR=7'h23, MEM_ADDR=OPADDR=7'h23, ICOUNT incremented.
3. Indirect: IR=12'h3C5 (I=1, ADDR=7'h45), RDR_EN=1, DBUS=12'h012 → EA=7'h12, OPADDR=7'h12. Then PC_LOAD=1 → PC=7'h12.
4. Priority and wrap: PC=7'h7F, PC_EN=1 → PC=0. Then PC_EN=1 with PC_LOAD=1 and OPADDR=7'h30 → PC=7'h30, not 7'h01.
5. Flags: ALU_EN=1 with CF_IN=1, OF_IN=0, SF_IN=1, ZF_IN=0 → CF=1, OF=0, SF=1, ZF=0. Then change the *_IN inputs with ALU_EN=0 → flags unchanged. RST=1 together with ALU_EN=1 → flags=0.
6. Counter wrap: preload ICOUNT toward 16'hFFFF, issue 2 IR_EN cycles → ICOUNT goes 16'hFFFF then 0.
